// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared defaults and helpers for the chunked pipelined adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Default operand width and bits added per pipeline stage
  localparam int c_default_width = 8;
  localparam int c_default_chunk = 4;

  // Number of pipeline stages needed to cover an operand of the given width
  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder
// Description : CHUNK-bit combinational adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder
  import adder_pkg::*;
#(
  parameter int CHUNK = c_default_chunk
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);

  // One extra bit on each operand captures the carry out of the chunk
  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit adder split into WIDTH/CHUNK pipeline stages. Each
//               stage adds one CHUNK of the operands plus the carry from the
//               previous stage. Unconsumed operand chunks ride along in skew
//               registers and finished sum chunks in deskew registers, so the
//               full sum is aligned at the last stage. Valid/ready handshake
//               with a single global advance enable (whole pipe stalls).
//               Optional macro PIPELINED_ADDER_OVF_EN adds a registered
//               signed-overflow output aligned with s.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CHUNK = c_default_chunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] addent,
  input  logic [WIDTH-1:0] augend,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  // The operands must split evenly into chunks
  if ((WIDTH % CHUNK) != 0) begin : g_check
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  // Whole pipe advances together; it only freezes when a result is waiting
  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                   r_v;
    logic                   r_c;
    logic [(k+1)*CHUNK-1:0] r_sum;

    logic [CHUNK-1:0]       w_a;
    logic [CHUNK-1:0]       w_b;
    logic [CHUNK-1:0]       w_s;
    logic                   w_ci;
    logic                   w_co;
    logic                   w_vi;
    logic [(k+1)*CHUNK-1:0] w_sum_nxt;

    // Stage inputs come from the ports at stage 0, else from stage k-1
    if (k == 0) begin : g_src
      assign w_a       = addent[CHUNK-1:0];
      assign w_b       = augend[CHUNK-1:0];
      assign w_ci      = cin;
      assign w_vi      = in_valid;
      assign w_sum_nxt = w_s;
    end else begin : g_src
      assign w_a       = g_stage[k-1].g_skew.r_a[CHUNK-1:0];
      assign w_b       = g_stage[k-1].g_skew.r_b[CHUNK-1:0];
      assign w_ci      = g_stage[k-1].r_c;
      assign w_vi      = g_stage[k-1].r_v;
      assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
    end

    chunk_adder #(
      .CHUNK (CHUNK)
    ) u_chunk_adder (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (w_ci),
      .o_s    (w_s),
      .o_cout (w_co)
    );

    // Valid, carry and accumulated sum chunks for this stage
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_en) begin
        r_v   <= w_vi;
        r_c   <= w_co;
        r_sum <= w_sum_nxt;
      end
    end

    // Operand chunks still to be added travel with the stage (none after last)
    if (k < STAGES - 1) begin : g_skew
      localparam int REM = WIDTH - (k + 1) * CHUNK;

      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      logic [REM-1:0] w_a_nxt;
      logic [REM-1:0] w_b_nxt;

      if (k == 0) begin : g_skew_src
        assign w_a_nxt = addent[WIDTH-1:CHUNK];
        assign w_b_nxt = augend[WIDTH-1:CHUNK];
      end else begin : g_skew_src
        assign w_a_nxt = g_stage[k-1].g_skew.r_a[REM+CHUNK-1:CHUNK];
        assign w_b_nxt = g_stage[k-1].g_skew.r_b[REM+CHUNK-1:CHUNK];
      end

      // Skew registers shift the remaining operand bits down one chunk
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;

`ifdef PIPELINED_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB's operand and sum bits
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_ovf_nxt = g_stage[STAGES-1].w_co ^
                     (g_stage[STAGES-1].w_a[CHUNK-1] ^
                      g_stage[STAGES-1].w_b[CHUNK-1] ^
                      g_stage[STAGES-1].w_s[CHUNK-1]);

  // Overflow flag is registered alongside the last stage so it aligns with s
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Scoreboard bench for pipelined_adder (WIDTH=8, CHUNK=4).
//               Define PIPELINED_ADDER_OVF_EN to also check ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] addent;
  logic [7:0] augend;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic       ovf;
`endif

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_pops  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  pipelined_adder #(
    .WIDTH (8),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addent    (addent),
    .augend    (augend),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    exp_t       e;
    t      = {1'b0, a} + {1'b0, b} + {8'b0, c};
    e.s    = t[7:0];
    e.cout = t[8];
    e.ovf  = (a[7] == b[7]) && (t[7] != a[7]);
    return e;
  endfunction

  // Monitor: compare every delivered result against the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got s=0x%0h cout=%0b, expected no output", s, cout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pops++;
        check("sum", {24'b0, s}, {24'b0, e.s});
        check("cout", {31'b0, cout}, {31'b0, e.cout});
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
      end
    end
  end

  // Offer one operand set; called at posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input exp_t e);
    bit rdy;
    int n;
    n        = 0;
    addent   = a;
    augend   = b;
    cin      = c;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      if (rdy) sb.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_total++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int cyc0;
    int pops0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    addent    = 8'h00;
    augend    = 8'h00;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_s", {24'b0, s}, 0);
    check("rst_cout", {31'b0, cout}, 0);
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_ovf", {31'b0, ovf}, 0);
`endif

    // Latency: accepted at edge t, visible after edge t+1
    send(8'h81, 8'h00, 1'b0, exp_t'{8'h81, 1'b0, 1'b0});
    check("lat_early", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'b0, out_valid}, 1);
    check("lat_s", {24'b0, s}, 32'h81);

    // Directed carry / wrap / overflow vectors
    send(8'hFF, 8'h01, 1'b0, exp_t'{8'h00, 1'b1, 1'b0});
    send(8'h0F, 8'h00, 1'b1, exp_t'{8'h10, 1'b0, 1'b0});
    send(8'h7F, 8'h01, 1'b0, exp_t'{8'h80, 1'b0, 1'b1});
    send(8'h80, 8'h80, 1'b0, exp_t'{8'h00, 1'b1, 1'b1});
    wait_drain();

    // Back-to-back stream: one acceptance per cycle
    pops0 = n_pops;
    cyc0  = cyc;
    for (int i = 0; i < 45; i++) begin
      logic [7:0] b;
      b = 8'(2 * i);
      send(8'h81, b, 1'b0, model(8'h81, b, 1'b0));
    end
    check("stream_accept_cycles", cyc - cyc0, 45);
    wait_drain();
    check("stream_results", n_pops - pops0, 45);

    // Stall with results pending
    pops0     = n_pops;
    out_ready = 1'b0;
    fork
      begin
        send(8'h55, 8'hAA, 1'b1, exp_t'{8'h00, 1'b1, 1'b0});
        send(8'h3C, 8'h44, 1'b0, exp_t'{8'h80, 1'b0, 1'b1});
        send(8'hF0, 8'h0F, 1'b0, exp_t'{8'hFF, 1'b0, 1'b0});
        send(8'hC8, 8'h90, 1'b0, exp_t'{8'h58, 1'b1, 1'b1});
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        check("stall_reach_valid", {31'b0, out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_in_ready", {31'b0, in_ready}, 0);
          check("stall_out_valid", {31'b0, out_valid}, 1);
          check("stall_s", {24'b0, s}, 0);
          check("stall_cout", {31'b0, cout}, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_results", n_pops - pops0, 4);

    // Reset one cycle after acceptance discards the in-flight set
    send(8'h12, 8'h34, 1'b0, exp_t'{8'h46, 1'b0, 1'b0});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_s", {24'b0, s}, 0);
    check("flush_in_ready", {31'b0, in_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("flush_out_valid", {31'b0, out_valid}, 0);
    end
    @(posedge clk);
    #1;

    // Recovery after reset
    pops0 = n_pops;
    send(8'h01, 8'h02, 1'b0, exp_t'{8'h03, 1'b0, 1'b0});
    wait_drain();
    check("recover_results", n_pops - pops0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports addent and augend, inputs, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: s and cout hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port s, output, WIDTH bits: the sum, which is addent+augend+cin mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-013 Stage k (k = 0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of both operands plus the carry registered from stage k-1, with cin used at stage 0.
REQ-014 Operand chunks not yet consumed SHALL travel in skew registers alongside each stage, and finished sum chunks SHALL travel in deskew registers, so that s is aligned at the output.
REQ-015 Advance enable SHALL be en = !out_valid || out_ready; all stage data, carry and valid registers SHALL load only when en=1.
REQ-016 in_ready SHALL equal en, combinationally.
REQ-017 A transfer SHALL occur on in_valid && in_ready; a transfer at edge t SHALL appear with out_valid=1 after edge t+STAGES-1 when there is no stall, giving a latency of STAGES cycles.
REQ-018 When en=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0; bubbles are not compressed.
REQ-019 While out_valid=1 and out_ready=0, s, cout, out_valid and all internal state SHALL hold unchanged.
REQ-020 The block SHALL sustain a throughput of one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-021 Results SHALL leave in acceptance order.
REQ-022 All-ones plus 1 SHALL wrap s to 0 with cout=1.
REQ-023 When WIDTH is not a multiple of CHUNK, elaboration SHALL fail.

Reset
REQ-024 When rst=1 at a clock edge, all valid bits SHALL clear, and s, cout and all data registers SHALL clear to 0; after that edge out_valid=0 and in_ready=1.
REQ-025 Reset mid-operation SHALL discard every in-flight operand set, with no partial result emitted.
REQ-026 rst SHALL take priority over any transfer in the same cycle.

Configuration
REQ-027 With macro PIPELINED_ADDER_OVF_EN defined, the block SHALL add output ovf, 1 bit, registered and aligned with s, equal to the two's-complement signed overflow (carry into MSB XOR cout); ovf SHALL reset to 0 and hold during a stall.
REQ-028 Without PIPELINED_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package adder_pkg SHALL hold the default WIDTH and CHUNK constants and the STAGES derivation function.
REQ-030 Sub-module chunk_adder SHALL implement one CHUNK-bit combinational add with carry-in and carry-out, instantiated STAGES times in a generate loop.

Verification (WIDTH=8, CHUNK=4)
REQ-031 Applying 0x81+0x00, cin=0, out_ready=1 SHALL give out_valid at cycle 2 with s=0x81, cout=0.
REQ-032 Applying 0xFF+0x01, cin=0 SHALL give s=0x00, cout=1; applying 0x0F+0x00, cin=1 SHALL give s=0x10, cout=0, exercising the inter-stage carry.
REQ-033 Streaming augend=0x00,0x02,...,0x58 (45 values) with addent=0x81 back-to-back SHALL give 45 consecutive results, one per cycle, each matching a reference model.
REQ-034 Holding out_ready=0 for 5 cycles while data is valid SHALL hold in_ready=0 and keep s and cout stable; on release, results SHALL resume with none lost or duplicated.
REQ-035 Asserting rst one cycle after accepting 0x12+0x34 SHALL keep out_valid=0 thereafter until new input.
REQ-036 With PIPELINED_ADDER_OVF_EN defined, 0x7F+0x01 SHALL give ovf=1, and 0x80+0x80 SHALL give ovf=1, cout=1, s=0x00.
